// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS generator/checker pair.
package prbs_pkg;

    localparam int MAX_N = 16;
    localparam logic [2:0] DEFAULT_TAPS_N3 = 3'b110;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Fibonacci shift-left successor on the low n bits of a MAX_N-wide word.
    function automatic logic [MAX_N-1:0] lfsr_next(
        input logic [MAX_N-1:0] word,
        input logic [MAX_N-1:0] taps,
        input int unsigned      n
    );
        logic [MAX_N-1:0] mask;
        logic             fb;
        mask = MAX_N'((32'd1 << n) - 32'd1);
        fb   = ^(word & taps);
        return ((word << 1) | MAX_N'(fb)) & mask;
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: lock detection, error strobe/count, lock-up flag.
// Optional period measurement over one full sequence when PRBS_PERIOD_CHECK_EN is defined.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int           N        = 3,
    parameter logic [N-1:0] TAPS     = N'(DEFAULT_TAPS_N3),
    parameter int           LOCK_CNT = 3,
    parameter int           LOSS_CNT = 2,
    parameter int           CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
`ifdef PRBS_PERIOD_CHECK_EN
    output logic             period_ok,
`endif
    output logic             stuck
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [N-1:0]     r_pred;
    logic [N-1:0]     w_pred_next;
    logic             r_first;
    logic             r_err_pulse;
    logic             r_stuck;

    logic [MAX_N-1:0] w_succ_in_full;
    logic [MAX_N-1:0] w_succ_pred_full;
    logic [N-1:0]     w_succ_in;
    logic [N-1:0]     w_succ_pred;

    logic             w_mismatch;
    logic             w_search_hit;
    logic             w_go_lock;
    logic             w_lock_err;
    logic             w_go_search;
    logic             w_match_inc;
    logic             w_miss_inc;
    logic [RUN_W-1:0]  w_match_run;
    logic [MISS_W-1:0] w_miss_run;

    assign w_succ_in_full   = lfsr_next(MAX_N'(in_data), MAX_N'(TAPS), N);
    assign w_succ_pred_full = lfsr_next(MAX_N'(r_pred), MAX_N'(TAPS), N);
    assign w_succ_in        = w_succ_in_full[N-1:0];
    assign w_succ_pred      = w_succ_pred_full[N-1:0];

    generate
        if (N < MAX_N) begin : g_unused
            logic w_unused_hi;
            assign w_unused_hi = ^{w_succ_in_full[MAX_N-1:N], w_succ_pred_full[MAX_N-1:N]};
        end
    endgenerate

    // All-zero words never match: the successor of zero is zero and would self-lock.
    assign w_mismatch   = r_first || (in_data != r_pred) || (in_data == '0);
    assign w_search_hit = in_valid && (r_state == SEARCH) && !w_mismatch;
    assign w_go_lock    = w_search_hit && (w_match_run == RUN_W'(LOCK_CNT - 1));
    assign w_lock_err   = in_valid && (r_state == LOCKED) && w_mismatch;
    assign w_go_search  = w_lock_err && (w_miss_run == MISS_W'(LOSS_CNT - 1));
    assign w_match_inc  = w_search_hit && !w_go_lock;
    assign w_miss_inc   = w_lock_err && !w_go_search;

    sat_counter #(.W(RUN_W)) u_match_run (
        .clk   (clk),
        .rst   (rst),
        .i_clr (in_valid && !w_match_inc),
        .i_inc (w_match_inc),
        .o_cnt (w_match_run)
    );

    sat_counter #(.W(MISS_W)) u_miss_run (
        .clk   (clk),
        .rst   (rst),
        .i_clr (in_valid && !w_miss_inc),
        .i_inc (w_miss_inc),
        .o_cnt (w_miss_run)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_lock_err),
        .o_cnt (err_cnt)
    );

    always_comb begin
        w_state_next = r_state;
        w_pred_next  = r_pred;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    w_pred_next = w_succ_in;
                    if (w_go_lock) begin
                        w_state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_go_search) begin
                        w_state_next = SEARCH;
                        w_pred_next  = w_succ_in;
                    end else begin
                        w_pred_next  = w_succ_pred;
                    end
                end
                default: w_state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_pred      <= '0;
            r_first     <= 1'b1;
            r_err_pulse <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pred      <= w_pred_next;
            r_err_pulse <= w_lock_err;
            if (in_valid) begin
                r_first <= 1'b0;
            end
            if (in_valid && (in_data == '0)) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;
    assign stuck     = r_stuck;

`ifdef PRBS_PERIOD_CHECK_EN
    logic [N-1:0] r_marker;
    logic [N:0]   r_period_cnt;
    logic         r_period_ok;
    logic [N:0]   w_period_cnt_inc;

    assign w_period_cnt_inc = (r_period_cnt == {(N+1){1'b1}}) ? r_period_cnt : r_period_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_marker     <= '0;
            r_period_cnt <= '0;
            r_period_ok  <= 1'b0;
        end else if (w_go_search) begin
            r_marker     <= '0;
            r_period_cnt <= '0;
        end else if (w_go_lock) begin
            r_marker     <= w_succ_in;
            r_period_cnt <= '0;
        end else if (in_valid && (r_state == LOCKED)) begin
            if (w_succ_pred == r_marker) begin
                r_period_ok  <= (w_period_cnt_inc == (N+1)'((32'd1 << N) - 32'd1));
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= w_period_cnt_inc;
            end
        end
    end

    assign period_ok = r_period_ok;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (N=3, TAPS=110) with a word-level reference model.
`timescale 1ns/1ps
module tb_prbs_checker;

    localparam int N        = 3;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int TAPS_I   = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       stuck;
`ifdef PRBS_PERIOD_CHECK_EN
    logic       period_ok;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_locked, m_pulse, m_stuck, m_first;
    int m_pred, m_match, m_miss, m_err;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
`ifdef PRBS_PERIOD_CHECK_EN
        .period_ok (period_ok),
`endif
        .stuck     (stuck)
    );

    function automatic int nxt(input int w);
        int fb = 0;
        for (int b = 0; b < N; b++) begin
            if (((TAPS_I >> b) & 1) == 1 && ((w >> b) & 1) == 1) fb ^= 1;
        end
        return ((w << 1) | fb) % (1 << N);
    endfunction

    function automatic logic [10:0] model_vec();
        return {m_locked, m_pulse, m_stuck, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pulse = 0; m_stuck = 0; m_first = 1;
        m_pred = 0; m_match = 0; m_miss = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int d);
        bit bad;
        m_pulse = 0;
        if (!v) return;
        bad = m_first || (d != m_pred) || (d == 0);
        m_first = 0;
        if (d == 0) m_stuck = 1;
        if (!m_locked) begin
            m_match = bad ? 0 : m_match + 1;
            m_pred = nxt(d);
            if (m_match == LOCK_CNT) begin
                m_locked = 1; m_match = 0; m_miss = 0;
            end
        end else begin
            m_pred = nxt(m_pred);
            if (bad) begin
                m_pulse = 1;
                if (m_err < 255) m_err++;
                m_miss++;
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0; m_match = 0; m_miss = 0; m_pred = nxt(d);
                end
            end else begin
                m_miss = 0;
            end
        end
    endtask

    task automatic step(input bit v, input int d);
        in_valid = v;
        in_data  = 3'(d);
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({locked, err_pulse, stuck, err_cnt} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %b want %b", {locked, err_pulse, stuck, err_cnt}, 11'd0);
        end
    endtask

    task automatic test_clean_lock();
        int seq [5] = '{1, 2, 5, 3, 7};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i]);
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec()) begin
                n_errors++;
                $display("FAIL clean_model w%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
            n_checks++;
            if (locked !== (i >= 3)) begin
                n_errors++;
                $display("FAIL clean_lock_time w%0d: locked=%b want %b", i, locked, (i >= 3));
            end
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL clean_err_cnt: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_single_corruption();
        int seq [9] = '{1, 2, 5, 3, 7, 7, 4, 1, 2};
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, seq[i]);
            if (err_pulse === 1'b1) pulses++;
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec()) begin
                n_errors++;
                $display("FAIL corrupt_model w%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
        end
        n_checks++;
        if (pulses != 1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL corrupt_once: pulses=%0d cnt=%0d locked=%b want 1/1/1", pulses, err_cnt, locked);
        end
    endtask

    task automatic test_loss_of_lock();
        int seq [9] = '{1, 2, 5, 3, 5, 5, 3, 7, 6};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, seq[i]);
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec()) begin
                n_errors++;
                $display("FAIL loss_model w%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
            if (i == 5) begin
                n_checks++;
                if (err_cnt !== 8'd2 || locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL loss_drop: cnt=%0d locked=%b want 2/0", err_cnt, locked);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL loss_relock: locked=%b cnt=%0d want 1/2", locked, err_cnt);
        end
    endtask

    task automatic test_idle_gaps();
        int seq [6] = '{1, 2, 5, 3, 7, 6};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, $urandom_range(0, 7));
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec() || err_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_gap g%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
            step(1, seq[i]);
            n_checks++;
            if (locked !== (i >= 3) || err_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_lock_time w%0d: locked=%b pulse=%b want %b/0", i, locked, err_pulse, (i >= 3));
            end
        end
    endtask

    task automatic test_stuck();
        int seq [5] = '{1, 2, 5, 3, 7};
        do_reset();
        step(1, 0);
        n_checks++;
        if (stuck !== 1'b1) begin
            n_errors++;
            $display("FAIL stuck_set: got %b want 1", stuck);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i]);
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec() || stuck !== 1'b1) begin
                n_errors++;
                $display("FAIL stuck_hold w%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
        end
        do_reset();
        n_checks++;
        if (stuck !== 1'b0) begin
            n_errors++;
            $display("FAIL stuck_clear: got %b want 0", stuck);
        end
    endtask

    task automatic test_async_reset();
        int pre [5] = '{1, 2, 5, 3, 6};
        int post [4] = '{1, 2, 5, 3};
        do_reset();
        for (int i = 0; i < 5; i++) step(1, pre[i]);
        n_checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd1 || err_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL async_pre: locked=%b cnt=%0d pulse=%b want 1/1/1", locked, err_cnt, err_pulse);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, err_pulse, stuck, err_cnt} !== 11'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %b want %b", {locked, err_pulse, stuck, err_cnt}, 11'd0);
        end
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, post[i]);
            n_checks++;
            if (locked !== (i >= 3) || {locked, err_pulse, stuck, err_cnt} !== model_vec()) begin
                n_errors++;
                $display("FAIL async_relock w%0d: got %b want %b", i, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
        end
    endtask

`ifdef PRBS_PERIOD_CHECK_EN
    task automatic test_period();
        int w = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, w);
            w = nxt(w);
        end
        for (int j = 0; j < 7; j++) begin
            step(1, w);
            w = nxt(w);
            n_checks++;
            if (period_ok !== (j == 6)) begin
                n_errors++;
                $display("FAIL period_ok w%0d: got %b want %b", j, period_ok, (j == 6));
            end
        end
    endtask
`endif

    task automatic test_random();
        int g = 1;
        int d;
        bit v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            d = g;
            if (v) begin
                if ($urandom_range(0, 19) < 2) d = $urandom_range(1, 7);
                if (c > 350 && $urandom_range(0, 15) == 0) d = 0;
                g = nxt(g);
            end
            step(v, d);
            n_checks++;
            if ({locked, err_pulse, stuck, err_cnt} !== model_vec()) begin
                n_errors++;
                $display("FAIL random c%0d: got %b want %b", c, {locked, err_pulse, stuck, err_cnt}, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_corruption();
        test_loss_of_lock();
        test_idle_gaps();
        test_stuck();
        test_async_reset();
`ifdef PRBS_PERIOD_CHECK_EN
        test_period();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the LFSR random generator.
- Consumes the generator's parallel N-bit output word stream, self-synchronises to it, and reports lock status and sequence errors.
- Used in bring-up and simulation to confirm the generator feeding serve-direction and ball-speed randomisation actually walks its full sequence, and to flag lock-up.

Parameters:
- N, 3, LFSR word width (min 2, max 16).
- TAPS, 3'b110 (N bits), feedback mask: fb = XOR-reduce(word & TAPS).
- LOCK_CNT, 3, consecutive correct predictions required to declare lock.
- LOSS_CNT, 2, consecutive mismatches in LOCKED that drop back to SEARCH.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_data holds a new generator word this cycle.
- in_data  in  N  generator word.
- locked  out  1  checker synchronised to the sequence.
- err_pulse  out  1  one-cycle strobe on a mismatch while LOCKED.
- err_cnt  out  CNT_W  saturating count of mismatches while LOCKED.
- stuck  out  1  all-zero word received; generator locked up.

Behaviour:
- Successor function: next(w) = {w[N-2:0], ^(w & TAPS)}.
- For N=3, TAPS=110 from 001 the sequence is 001,010,101,011,111,110,100,001 (period 7).
- Reset values: locked=0, err_pulse=0, err_cnt=0, stuck=0, state=SEARCH, prediction register=0, run counters=0.
- Only cycles with in_valid=1 are processed; idle cycles change nothing except err_pulse, which returns to 0.
- All outputs are registered: a response appears on the clock edge after the relevant valid word.
- SEARCH:
  - prediction := next(in_data) every valid word (reseed from the received word).
  - If in_data == previous prediction, increment match run; otherwise clear it to 0.
  - When the match run reaches LOCK_CNT, go to LOCKED; locked=1 from the following cycle.
  - The first valid word after reset never counts as a match, because the prediction is invalid; a first-word flag handles this.
- LOCKED:
  - prediction := next(prediction); free-runs and never reseeds, so one corrupted word yields exactly one error.
  - On mismatch: err_pulse=1 for one cycle; err_cnt increments and saturates at all-ones; miss run increments.
  - On match: miss run clears.
  - When the miss run reaches LOSS_CNT, go to SEARCH: locked=0, match run=0, and prediction reseeds from that word.
- stuck:
  - Set on any valid in_data == 0, in either state; sticky until rst.
  - An all-zero word is also treated as a mismatch.
- err_cnt is not cleared on loss of lock; only rst clears it.
- rst asserted mid-stream: all state returns to reset values immediately (asynchronous); re-lock requires a fresh LOCK_CNT matches.

Optional Feature:
- Macro: PRBS_PERIOD_CHECK_EN.
- With the macro defined:
  - Extra output period_ok (1 bit, reset 0).
  - On entering LOCKED, the current prediction is captured as a marker.
  - A counter then counts valid words until the prediction equals the marker again.
  - period_ok := (count == 2^N-1), evaluated at each return to the marker.
  - Counter and marker clear on loss of lock.
- Without the macro: no port, no counter, no marker logic.

Decomposition:
- Shared package prbs_pkg:
  - state enum {SEARCH, LOCKED}.
  - Function lfsr_next(word, taps), reused by the generator.
  - Default-taps constant for N=3.
- One natural sub-module: sat_counter (width-parameterised saturating incrementer with clear), used for err_cnt and the match/miss runs.

Test Plan:
- Clean stream: feed 001,010,101,011,111 with in_valid=1 each cycle. Match run hits 3 on the 4th word (011); locked=1 the next cycle; err_cnt=0.
- Single corruption: while LOCKED, replace 110 with 111. Exactly one err_pulse, err_cnt=1, locked stays 1; the next word 100 matches.
- Loss of lock: while LOCKED, two consecutive wrong words. err_cnt=2, locked=0. A following clean run from the new seed re-locks after 3 matches.
- Idle gaps: insert in_valid=0 cycles between every word of the clean sequence. Lock timing is identical in valid-word count; no err_pulse.
- Lock-up: in_data=000 with in_valid=1. stuck=1 on the next edge and remains 1 after clean words; cleared only by rst.
- Async reset: assert rst for 3 ns mid-sequence while LOCKED (not clock-aligned). All outputs 0 immediately. With PRBS_PERIOD_CHECK_EN defined, a full N=3 run gives period_ok=1 after 7 words past lock.
